cnn_layer_sequencer: RTL and testbench

Program-driven scheduler that sits in front of the CNN control FSM. It owns that controller's 14-bit op-code input and issues a host-loaded list of layer op codes to it one at a time. For each layer it waits for the controller's completion pulse and forces a zero (idle) op code between layers so the controller re-arms cleanly. It reports busy, done and error status to the host, and includes a per-layer watchdog.

---
 rtl/cnn_pkg.sv | 48 ++++
 rtl/seq_prog_mem.sv | 35 +++
 rtl/cnn_layer_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_cnn_layer_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared definitions for the CNN layer sequencer.
//   - op_type_e   : the 3-bit layer type held in op-code bits [2:0]
//   - field slice : bit positions of type, filter count and element count
//   - seq_state_e : sequencer FSM states
//   - ERR_*       : encodings reported on err_cause_o
//   - is_legal_type(): true for the types that may be issued to the controller
package cnn_pkg;

    typedef enum logic [2:0] {
        OP_IDLE         = 3'b000,
        OP_CONV         = 3'b001,
        OP_CONV_POOL    = 3'b010,
        OP_FC           = 3'b011,
        OP_CONV_POOL_FC = 3'b110,
        OP_OUT          = 3'b111
    } op_type_e;

    localparam int TYPE_LSB = 0;
    localparam int TYPE_MSB = 2;
    localparam int FILT_LSB = 3;
    localparam int FILT_MSB = 8;
    localparam int ELEM_LSB = 9;
    localparam int ELEM_MSB = 13;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_WAIT   = 3'd3,
        ST_GAP    = 3'd4,
        ST_ERROR  = 3'd5
    } seq_state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // Types that are issued to the controller; NOP (000) is handled separately.
    function automatic logic is_legal_type(input logic [2:0] typ);
        logic legal;
        case (typ)
            OP_CONV, OP_CONV_POOL, OP_FC, OP_CONV_POOL_FC, OP_OUT: legal = 1'b1;
            default:                                              legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/seq_prog_mem.sv
// seq_prog_mem: DEPTH x OPW program store for the layer sequencer.
// One synchronous write port and one synchronous read port (data appears the
// cycle after the address). Contents are deliberately not reset so a program
// survives a sequencer reset.
//   clk   : clock
//   we    : write strobe
//   waddr : write slot
//   wdata : op code to store
//   raddr : read slot
//   rdata : registered read data
module seq_prog_mem
    import cnn_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int OPW   = 14
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [OPW-1:0]           wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [OPW-1:0]           rdata
);

    logic [OPW-1:0] mem_r [DEPTH];

    // Write port and registered read port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
        rdata <= mem_r[raddr];
    end

endmodule

// File: rtl/cnn_layer_sequencer.sv
// cnn_layer_sequencer: issues a host-loaded list of layer op codes to the CNN
// control FSM, one at a time, with a zero op code between layers and a
// per-layer watchdog.
//   clk, rst        : clock, synchronous active-high reset
//   prog_we/addr/data: program load port (IDLE only)
//   prog_len        : number of layers, sampled at start
//   start, abort    : run request / cancel or clear error
//   layer_done_i    : completion pulse from the CNN controller
//   op_code_o, op_valid_o : op code to the controller (non-zero only in WAIT)
//   layer_idx_o     : current program index
//   busy_o, done_o, err_o, err_cause_o : host status
module cnn_layer_sequencer
    import cnn_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int OPW     = 14,
    parameter int TIMEOUT = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  logic [OPW-1:0]           prog_data,
    input  logic [$clog2(DEPTH):0]   prog_len,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     layer_done_i,
    output logic [OPW-1:0]           op_code_o,
    output logic                     op_valid_o,
    output logic [$clog2(DEPTH)-1:0] layer_idx_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o,
    output logic [1:0]               err_cause_o
);

    localparam int AW  = $clog2(DEPTH);
    localparam int WDW = $clog2(TIMEOUT);
    localparam logic [AW-1:0]  IDX_ONE = 1;
    localparam logic [AW:0]    LEN_ONE = 1;
    localparam logic [WDW-1:0] WD_ONE  = 1;
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    seq_state_e     state_r;
    logic [AW:0]    len_r;
    logic [WDW-1:0] wd_r;
    logic [OPW-1:0] rd_data_s;
    logic [2:0]     typ_s;
    logic           last_s;
    logic           mem_we_s;

    assign mem_we_s = prog_we && (state_r == ST_IDLE);
    assign typ_s    = rd_data_s[TYPE_MSB:TYPE_LSB];
    // len_r is never zero while a run is active, so len_r-1 cannot wrap there.
    assign last_s   = ({1'b0, layer_idx_o} == (len_r - LEN_ONE));

    seq_prog_mem #(
        .DEPTH (DEPTH),
        .OPW   (OPW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we_s),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (layer_idx_o),
        .rdata (rd_data_s)
    );

    // Sequencer FSM with index, length latch, watchdog and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            len_r       <= '0;
            wd_r        <= '0;
            layer_idx_o <= '0;
            op_code_o   <= '0;
            op_valid_o  <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            err_cause_o <= ERR_NONE;
        end else begin
            done_o <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start && !abort) begin
                        if (prog_len != '0) begin
                            len_r       <= prog_len;
                            layer_idx_o <= '0;
                            busy_o      <= 1'b1;
                            state_r     <= ST_FETCH;
                        end else begin
                            done_o <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    if (abort) begin
                        busy_o  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (abort) begin
                        busy_o  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else if (typ_s == OP_IDLE) begin
                        // NOP slot: skip it without touching the controller.
                        if (last_s) begin
                            busy_o  <= 1'b0;
                            done_o  <= 1'b1;
                            state_r <= ST_IDLE;
                        end else begin
                            layer_idx_o <= layer_idx_o + IDX_ONE;
                            state_r     <= ST_FETCH;
                        end
                    end else if (is_legal_type(typ_s)) begin
                        op_code_o  <= rd_data_s;
                        op_valid_o <= 1'b1;
                        wd_r       <= '0;
                        state_r    <= ST_WAIT;
                    end else begin
                        busy_o      <= 1'b0;
                        err_o       <= 1'b1;
                        err_cause_o <= ERR_ILLEGAL;
                        state_r     <= ST_ERROR;
                    end
                end
                ST_WAIT: begin
                    if (abort) begin
                        op_code_o  <= '0;
                        op_valid_o <= 1'b0;
                        busy_o     <= 1'b0;
                        state_r    <= ST_IDLE;
                    end else if (layer_done_i) begin
                        // Completion on the final watchdog cycle still advances.
                        op_code_o  <= '0;
                        op_valid_o <= 1'b0;
                        state_r    <= ST_GAP;
                    end else if (wd_r == WD_LAST) begin
                        op_code_o   <= '0;
                        op_valid_o  <= 1'b0;
                        busy_o      <= 1'b0;
                        err_o       <= 1'b1;
                        err_cause_o <= ERR_TIMEOUT;
                        state_r     <= ST_ERROR;
                    end else begin
                        wd_r <= wd_r + WD_ONE;
                    end
                end
                ST_GAP: begin
                    if (abort) begin
                        busy_o  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else if (last_s) begin
                        busy_o  <= 1'b0;
                        done_o  <= 1'b1;
                        state_r <= ST_IDLE;
                    end else begin
                        layer_idx_o <= layer_idx_o + IDX_ONE;
                        state_r     <= ST_FETCH;
                    end
                end
                ST_ERROR: begin
                    // layer_idx_o stays at the faulting slot until cleared.
                    if (abort) begin
                        err_o       <= 1'b0;
                        err_cause_o <= ERR_NONE;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    op_code_o   <= '0;
                    op_valid_o  <= 1'b0;
                    busy_o      <= 1'b0;
                    err_o       <= 1'b0;
                    err_cause_o <= ERR_NONE;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Directed testbench for cnn_layer_sequencer (TIMEOUT = 64).
module tb_cnn_layer_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [13:0] prog_data;
    logic [4:0]  prog_len;
    logic        start;
    logic        abort;
    logic        layer_done_i;
    logic [13:0] op_code_o;
    logic        op_valid_o;
    logic [3:0]  layer_idx_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [1:0]  err_cause_o;

    int total = 0;
    int bad   = 0;

    cnn_layer_sequencer #(
        .DEPTH   (16),
        .OPW     (14),
        .TIMEOUT (64)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .prog_we      (prog_we),
        .prog_addr    (prog_addr),
        .prog_data    (prog_data),
        .prog_len     (prog_len),
        .start        (start),
        .abort        (abort),
        .layer_done_i (layer_done_i),
        .op_code_o    (op_code_o),
        .op_valid_o   (op_valid_o),
        .layer_idx_o  (layer_idx_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .err_cause_o  (err_cause_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic prog_write(input logic [3:0] a, input logic [13:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic do_start(input logic [4:0] len);
        start = 1'b1; prog_len = len;
        tick();
        start = 1'b0;
    endtask

    // Counts cycles with op_valid_o low until it rises (bounded).
    task automatic wait_valid(output int n);
        n = 0;
        while (op_valid_o !== 1'b1 && n < 100) begin
            n++;
            tick();
        end
    endtask

    // Model controller: accept an op, answer with layer_done 20 cycles later.
    task automatic serve_layer(input string tag, input logic [13:0] exp_op,
                               input logic [3:0] exp_idx, input int exp_zeros);
        int n;
        wait_valid(n);
        chk({tag, "_zeros"}, n, exp_zeros);
        chk({tag, "_op"}, op_code_o, exp_op);
        chk({tag, "_idx"}, layer_idx_o, exp_idx);
        repeat (19) tick();
        chk({tag, "_hold"}, {op_valid_o, op_code_o}, {1'b1, exp_op});
        layer_done_i = 1'b1;
        tick();
        layer_done_i = 1'b0;
        chk({tag, "_gap"}, {op_valid_o, op_code_o, busy_o}, {1'b0, 14'h0000, 1'b1});
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "global timeout");
    end

    initial begin
        rst = 1'b1; prog_we = 1'b0; prog_addr = 4'd0; prog_data = 14'h0000;
        prog_len = 5'd0; start = 1'b0; abort = 1'b0; layer_done_i = 1'b0;
        repeat (3) tick();
        chk("reset_outputs", {op_code_o, op_valid_o, layer_idx_o, busy_o, done_o, err_o, err_cause_o}, 32'h0);
        rst = 1'b0;
        tick();

        // Three-layer program.
        prog_write(4'd0, 14'h0041);
        prog_write(4'd1, 14'h0042);
        prog_write(4'd2, 14'h0007);
        do_start(5'd3);
        chk("p1_fetch", {busy_o, op_valid_o, op_code_o}, {1'b1, 1'b0, 14'h0000});
        serve_layer("p1_l0", 14'h0041, 4'd0, 2);
        serve_layer("p1_l1", 14'h0042, 4'd1, 3);
        serve_layer("p1_l2", 14'h0007, 4'd2, 3);
        tick();
        chk("p1_done", {done_o, busy_o}, {1'b1, 1'b0});
        tick();
        chk("p1_done_end", done_o, 1'b0);

        // NOP in slot 1 is skipped.
        prog_write(4'd0, 14'h0001);
        prog_write(4'd1, 14'h0000);
        prog_write(4'd2, 14'h0003);
        do_start(5'd3);
        serve_layer("p2_l0", 14'h0001, 4'd0, 2);
        serve_layer("p2_l2", 14'h0003, 4'd2, 5);
        tick();
        chk("p2_done", {done_o, busy_o}, {1'b1, 1'b0});
        tick();
        chk("p2_done_end", done_o, 1'b0);

        // Illegal type in slot 1.
        prog_write(4'd0, 14'h0041);
        prog_write(4'd1, 14'h0004);
        do_start(5'd2);
        serve_layer("p3_l0", 14'h0041, 4'd0, 2);
        repeat (3) tick();
        chk("p3_err", {err_o, err_cause_o, layer_idx_o, op_code_o, busy_o},
            {1'b1, 2'b01, 4'd1, 14'h0000, 1'b0});
        do_start(5'd2);
        chk("p3_start_ignored", {err_o, busy_o}, {1'b1, 1'b0});
        abort = 1'b1; tick(); abort = 1'b0;
        chk("p3_abort_clear", {err_o, err_cause_o, busy_o}, {1'b0, 2'b00, 1'b0});

        // Watchdog expiry after exactly 64 WAIT cycles.
        do_start(5'd1);
        begin
            int n;
            wait_valid(n);
            chk("p4_lat", n, 2);
        end
        repeat (63) tick();
        chk("p4_wait64", {err_o, op_valid_o}, {1'b0, 1'b1});
        tick();
        chk("p4_timeout", {err_o, err_cause_o, op_code_o, op_valid_o, layer_idx_o},
            {1'b1, 2'b10, 14'h0000, 1'b0, 4'd0});
        abort = 1'b1; tick(); abort = 1'b0;
        chk("p4_abort_clear", {err_o, err_cause_o}, {1'b0, 2'b00});

        // layer_done on the final watchdog cycle wins.
        do_start(5'd1);
        begin
            int n;
            wait_valid(n);
            chk("p5_lat", n, 2);
        end
        repeat (63) tick();
        layer_done_i = 1'b1; tick(); layer_done_i = 1'b0;
        chk("p5_gap", {err_o, op_code_o, busy_o}, {1'b0, 14'h0000, 1'b1});
        tick();
        chk("p5_done", {done_o, err_o, busy_o}, {1'b1, 1'b0, 1'b0});

        // Abort in WAIT, with a write attempt while busy.
        do_start(5'd1);
        begin
            int n;
            wait_valid(n);
            chk("p6_lat", n, 2);
        end
        prog_write(4'd0, 14'h0007);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("p6_abort", {op_code_o, op_valid_o, busy_o, done_o}, {14'h0000, 1'b0, 1'b0, 1'b0});
        tick();
        chk("p6_no_done", done_o, 1'b0);

        // Zero-length start.
        do_start(5'd0);
        chk("p7_len0_done", {done_o, busy_o}, {1'b1, 1'b0});
        tick();
        chk("p7_len0_end", {done_o, busy_o, op_valid_o}, {1'b0, 1'b0, 1'b0});

        // start and abort together: abort wins.
        abort = 1'b1;
        do_start(5'd1);
        abort = 1'b0;
        chk("p8_start_abort", {busy_o, done_o}, {1'b0, 1'b0});

        // Reset mid-WAIT, then rerun the retained program.
        do_start(5'd1);
        begin
            int n;
            wait_valid(n);
            chk("p9_lat", n, 2);
        end
        repeat (4) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("p9_rst_outputs", {op_code_o, op_valid_o, layer_idx_o, busy_o, done_o, err_o, err_cause_o}, 32'h0);
        tick();
        do_start(5'd1);
        serve_layer("p9_rerun", 14'h0041, 4'd0, 2);
        tick();
        chk("p9_done", {done_o, busy_o}, {1'b1, 1'b0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
